// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Receives instruction bytes from a byte-wide source. It packs each group of
//   four bytes big-endian into a 32-bit word and writes that word into a
//   word-addressed instruction memory, one write per word.
//
// Ports
//   clk          single clock; all state updates happen on its rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle load request; only sampled while IDLE
//   num_words    number of words to load; sampled together with start and
//                clamped to DEPTH
//   byte_valid   the source has a byte on byte_data
//   byte_data    incoming instruction byte
//   byte_ready   the loader accepts a byte in this cycle
//   mem_we       memory write strobe, one cycle per word
//   mem_addr     byte address of the word being written (word index * 4)
//   mem_wdata    assembled instruction word
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a load completes
//   word_count   number of words written in the current or last load
//   err          checksum mismatch flag
//
// Build option
//   LOADER_CHECKSUM_EN  When this macro is defined, the loader keeps a running
//                       XOR of the written words. After the last word it
//                       takes a 4-byte big-endian trailer and compares the
//                       trailer with the XOR. Without the macro, err is tied
//                       to 0 and no checksum logic exists.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// RECV   | accepting the four bytes of the next word
// WRITE  | one-cycle memory write of the assembled word
// CHECK  | accepting the checksum trailer (LOADER_CHECKSUM_EN only)
// DONE   | one-cycle done pulse, then back to IDLE

module instr_mem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_count,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_word_count;
    logic [CNT_W-1:0] w_wc_inc;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_shift;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      w_word;
    logic             w_accept;
    logic             w_fourth;

    assign w_accept = byte_valid & byte_ready;
    assign w_fourth = w_accept && (r_byte_idx == 2'd3);
    // The current byte is combined with the first three held bytes, so the
    // full word is ready on the same edge as the fourth accept.
    assign w_word   = {r_shift, byte_data};
    assign w_wc_inc = r_word_count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (num_words == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                byte_ready = 1'b1;
                if (w_fourth) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (w_wc_inc < r_n) begin
                    w_next = S_RECV;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_DONE;
`endif
                end
            end
            S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                byte_ready = 1'b1;
                if (w_fourth) begin
                    w_next = S_DONE;
                end
`else
                w_next = S_IDLE;
`endif
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n          <= '0;
            r_word_count <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_n          <= (num_words > L_DEPTH) ? L_DEPTH : num_words;
                r_word_count <= '0;
                r_byte_idx   <= '0;
            end
            if (w_accept) begin
                r_shift    <= {r_shift[15:0], byte_data};
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            // Address and data are registered when the word completes. They
            // then stay valid through WRITE and hold until the next word.
            if (r_state == S_RECV && w_fourth) begin
                r_mem_addr  <= 32'({r_word_count, 2'b00});
                r_mem_wdata <= w_word;
            end
            if (r_state == S_WRITE) begin
                r_word_count <= w_wc_inc;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_csum;
    logic        r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_csum <= '0;
                r_err  <= 1'b0;
            end
            if (r_state == S_WRITE) begin
                r_csum <= r_csum ^ r_mem_wdata;
            end
            if (r_state == S_CHECK && w_fourth) begin
                r_err <= (w_word != r_csum);
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_word_count;

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit instruction words in the target memory.
REQ-002 SHALL have parameter CNT_W, default 7, meaning width of word-count signals, sufficient to hold DEPTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 num_words  input  CNT_W  number of words to load; sampled in the start cycle.
REQ-007 byte_valid  input  1  source has a byte on byte_data.
REQ-008 byte_data  input  8  incoming instruction byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  write strobe to instruction memory, one cycle per word.
REQ-011 mem_addr  output  32  byte address of the word written: word index times 4, always word-aligned.
REQ-012 mem_wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on load completion.
REQ-015 word_count  output  CNT_W  number of words written in the current or last load.
REQ-016 err  output  1  checksum mismatch flag.

Function
REQ-017 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE.
REQ-018 IDLE -> RECV on start=1; SHALL latch N = num_words, clamped to DEPTH if above; clear word_count, err, byte index.
REQ-019 start with num_words=0 SHALL go IDLE -> DONE and issue no writes.
REQ-020 start while not IDLE SHALL be ignored.
REQ-021 byte_ready SHALL be 1 only in RECV and CHECK; a byte is accepted when byte_valid and byte_ready are both 1 on a rising edge.
REQ-022 Bytes SHALL be packed big-endian: first accepted byte -> bits [31:24], fourth -> bits [7:0].
REQ-023 On the fourth accepted byte SHALL go RECV -> WRITE; byte_ready is 0 in WRITE.
REQ-024 In WRITE, mem_we=1 for exactly one cycle, mem_addr = word_count*4, mem_wdata = assembled word; word_count increments at the end of that cycle.
REQ-025 After WRITE: if incremented word_count < N -> RECV; else CHECK when LOADER_CHECKSUM_EN is defined, otherwise DONE.
REQ-026 Minimum time per word SHALL be 5 cycles: 4 accept cycles plus 1 WRITE cycle; byte_valid low stalls without loss of state.
REQ-027 DONE SHALL assert done=1 for one cycle and then return to IDLE; word_count holds its value until the next start.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-029 The address SHALL never exceed (DEPTH-1)*4; there is no wrap-around within a load.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and set byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, word_count=0, err=0, byte index=0, checksum=0.
REQ-031 Reset during a load SHALL abort it with no further writes and no done pulse; a partial word is discarded.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN: when defined, SHALL keep a running XOR of all written words and, in CHECK, accept 4 more bytes (big-endian, not written to memory), set err=1 if they differ from the XOR, then go to DONE.
REQ-033 Without LOADER_CHECKSUM_EN, CHECK SHALL be unreachable, err SHALL be constant 0, and no checksum logic SHALL exist.

Verification
REQ-034 start, num_words=2, bytes 20 08 00 05 8C 09 00 04 continuously valid -> writes at addr 0x0 data 0x20080005 and addr 0x4 data 0x8C090004, spaced 5 cycles apart; done pulse; word_count=2.
REQ-035 byte_valid deasserted 3 cycles between bytes 2 and 3 -> same word written, WRITE delayed 3 cycles, no extra mem_we.
REQ-036 start with num_words=100 (DEPTH=64) -> exactly 64 writes, last at addr 0xFC, word_count=64.
REQ-037 rst_n low after 6 bytes of a 2-word load -> one write only (addr 0x0), state IDLE, no done pulse; a new start loads from addr 0x0.
REQ-038 With LOADER_CHECKSUM_EN: words 0x11111111, 0x22222222, trailer 33 33 33 33 -> err=0; trailer 00 00 00 00 -> err=1; in both cases no write for the trailer.
REQ-039 start with num_words=0 -> done pulse 1 cycle later, no mem_we, word_count=0.
